// File: rtl/pipe_pkg.sv
// Shared types for the destination-tag pipeline: tag width, tag type and
// the "no write" tag value.
package pipe_pkg;

  localparam int REG_W = 3;

  typedef logic [REG_W-1:0] dest_t;

  localparam dest_t DEST_NONE = '0;

endpackage : pipe_pkg

// File: rtl/hazard_dest_pipe_if.sv
// Bus between the hazard unit (master) and the destination-tag pipe (slave).
// The master drives stall/flush and the ID-stage instruction; the slave
// returns the per-stage destination tags and the stall statistics.
interface hazard_dest_pipe_if #(
  parameter int CNT_W = 16
) ();

  logic                pipeline_stall_n;
  logic                flush;
  logic                id_valid;
  logic                id_writes_reg;
  pipe_pkg::dest_t     id_op_dest;
  pipe_pkg::dest_t     ex_op_dest;
  pipe_pkg::dest_t     mem_op_dest;
  pipe_pkg::dest_t     wb_op_dest;
  logic [CNT_W-1:0]    stall_total;
  logic                stall_timeout;

  modport master (
    output pipeline_stall_n, flush, id_valid, id_writes_reg, id_op_dest,
    input  ex_op_dest, mem_op_dest, wb_op_dest, stall_total, stall_timeout
  );

  modport slave (
    input  pipeline_stall_n, flush, id_valid, id_writes_reg, id_op_dest,
    output ex_op_dest, mem_op_dest, wb_op_dest, stall_total, stall_timeout
  );

endinterface : hazard_dest_pipe_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous
// clear. Clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_q;

  // Count register: reset, clear, saturating increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != CNT_MAX)) begin
      r_q <= r_q + W'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/hazard_dest_pipe.sv
// Destination-tag pipe for the EX/MEM/WB stages. Tags move down every cycle
// (downstream never stalls); a stall or flush loads a bubble into EX. Stall
// cycles are counted, and an over-long stall run raises a sticky timeout
// that points at a deadlocked hazard unit. All outputs come from flops, so
// the hazard unit can close its loop through this block without a
// combinational cycle.
module hazard_dest_pipe
  import pipe_pkg::*;
#(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_dest_pipe_if.slave bus
);

  localparam int             RUN_W     = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  dest_t            r_ex_dest;
  dest_t            r_mem_dest;
  dest_t            r_wb_dest;
  logic             r_timeout;

  logic             w_stall;
  logic             w_load;
  dest_t            w_ex_next;
  logic [RUN_W-1:0] w_run;
  logic [CNT_W-1:0] w_total;
  logic             w_run_at_limit;

  // EX-load mux: only a live, register-writing, unstalled, unflushed
  // instruction enters EX; everything else becomes a bubble.
  always_comb begin
    w_stall        = ~bus.pipeline_stall_n;
    w_load         = bus.pipeline_stall_n & ~bus.flush & bus.id_valid & bus.id_writes_reg;
    w_run_at_limit = (w_run >= RUN_LIMIT);
    if (w_load) begin
      w_ex_next = bus.id_op_dest;
    end else begin
      w_ex_next = DEST_NONE;
    end
  end

  // Stage registers: EX takes the mux output, MEM and WB shift unconditionally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_dest  <= DEST_NONE;
      r_mem_dest <= DEST_NONE;
      r_wb_dest  <= DEST_NONE;
    end else begin
      r_ex_dest  <= w_ex_next;
      r_mem_dest <= r_ex_dest;
      r_wb_dest  <= r_mem_dest;
    end
  end

  // Length of the current run of consecutive stall cycles.
  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .clr   (~w_stall),
    .q     (w_run)
  );

  // Total stalled cycles since reset, saturating.
  sat_counter #(.W(CNT_W)) u_total_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .clr   (1'b0),
    .q     (w_total)
  );

  // Sticky timeout: this stall cycle would make the run exceed MAX_STALL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_stall && w_run_at_limit) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end

  assign bus.ex_op_dest    = r_ex_dest;
  assign bus.mem_op_dest   = r_mem_dest;
  assign bus.wb_op_dest    = r_wb_dest;
  assign bus.stall_total   = w_total;
  assign bus.stall_timeout = r_timeout;

endmodule : hazard_dest_pipe
